// File: rtl/multi_channel_sum_using_fifos_and_double_buffer.sv
// multi_channel_sum_using_fifos_and_double_buffer: per-channel FIFOs joined into a lane-wise sum
// that is emitted through a 2-entry double buffer, with wrap/saturate mode and an overflow flag.
module multi_channel_sum_using_fifos_and_double_buffer #(
    parameter int width    = 8,
    parameter int depth    = 10,
    parameter int n_ch     = 3,
    parameter int saturate = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [n_ch-1:0]         in_valid,
    output logic [n_ch-1:0]         in_ready,
    input  logic [n_ch*width-1:0]   in_data,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic [width-1:0]        sum_data,
    output logic                    sum_ovf
);
    localparam int pw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam int sw = width + $clog2(n_ch);
    logic [n_ch-1:0] empty;
    logic [width-1:0] head [n_ch];
    logic pop, up_ready, ovf, skid_valid;
    logic [sw-1:0] total;
    logic [width-1:0] res;
    logic [width:0] skid;
    assign pop = ~|empty & up_ready;
    genvar g;
    for (g = 0; g < n_ch; g++) begin : g_ch
        logic [width-1:0] mem [depth];
        logic [pw-1:0] wr_ptr, rd_ptr;
        logic [cw-1:0] count;
        logic push;
        assign in_ready[g] = count != cw'(depth);
        assign empty[g] = count == '0;
        assign push = in_valid[g] & in_ready[g];
        assign head[g] = mem[rd_ptr];
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr == pw'(depth - 1) ? '0 : wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr == pw'(depth - 1) ? '0 : rd_ptr + 1'b1;
                count <= count + cw'(push) - cw'(pop);
            end
        always_ff @(posedge clk)
            if (push) mem[wr_ptr] <= in_data[g*width +: width];
    end
    always_comb begin
        total = '0;
        for (int i = 0; i < n_ch; i++) total = total + sw'(head[i]);
    end
    assign ovf = |total[sw-1:width];
    assign res = (saturate != 0) && ovf ? '1 : total[width-1:0];
    // Second entry absorbs a pop that lands while the output register is stalled.
    assign up_ready = ~skid_valid;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sum_valid <= 1'b0;
            sum_data <= '0;
            sum_ovf <= 1'b0;
            skid <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (sum_ready) begin
                {sum_ovf, sum_data} <= skid;
                skid_valid <= 1'b0;
            end
        end else if (!sum_valid || sum_ready) begin
            sum_valid <= pop;
            if (pop) {sum_ovf, sum_data} <= {ovf, res};
        end else if (pop) begin
            skid <= {ovf, res};
            skid_valid <= 1'b1;
        end
endmodule
